// File: rtl/cam_update.sv
`default_nettype none
// ============================================================================
//  Module      : cam_update
//  Description : Update engine for a small content-addressable table.
//                Accepts one INSERT / DELETE / CLEAR / NOP request at a time.
//                INSERT and DELETE scan every entry, one per cycle, to find
//                the lowest valid match and the lowest free slot, then apply
//                the result in a single COMMIT cycle. Each request finishes
//                with a one-cycle response pulse.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            sole clock, rising edge
//    rst_n          synchronous active-low reset
//    i_req_valid    request present
//    o_req_ready    request can be accepted (IDLE only)
//    i_req_op       00 NOP, 01 INSERT, 10 DELETE, 11 CLEAR
//    i_req_key      key to insert or delete
//    o_rsp_valid    one-cycle response pulse
//    o_rsp_status   00 OK, 01 DUPLICATE, 10 FULL, 11 NOT_FOUND (held)
//    o_rsp_addr     entry index affected or matched (held)
//    o_entry_valid  per-entry valid bits
//    o_entry_count  number of valid entries
//    i_rd_addr      lookup-side read index
//    o_rd_data      stored key at i_rd_addr (combinational, valid or not)
// ============================================================================
module cam_update #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [1:0]       i_req_op,
    input  logic [WIDTH-1:0] i_req_key,
    output logic             o_rsp_valid,
    output logic [1:0]       o_rsp_status,
    output logic [AW-1:0]    o_rsp_addr,
    output logic [DEPTH-1:0] o_entry_valid,
    output logic [CW-1:0]    o_entry_count,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    localparam logic [1:0] c_OP_NOP    = 2'b00;
    localparam logic [1:0] c_OP_INSERT = 2'b01;
    localparam logic [1:0] c_OP_DELETE = 2'b10;
    localparam logic [1:0] c_OP_CLEAR  = 2'b11;

    localparam logic [1:0] c_ST_OK        = 2'b00;
    localparam logic [1:0] c_ST_DUPLICATE = 2'b01;
    localparam logic [1:0] c_ST_FULL      = 2'b10;
    localparam logic [1:0] c_ST_NOT_FOUND = 2'b11;

    localparam logic [AW-1:0] c_LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_COMMIT = 3'd2,
        S_CLEAR  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [CW-1:0]      r_count;

    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_key;
    logic [AW-1:0]      r_idx;
    logic               r_match_found;
    logic [AW-1:0]      r_match_idx;
    logic               r_free_found;
    logic [AW-1:0]      r_free_idx;

    logic [1:0]         r_rsp_status;
    logic [AW-1:0]      r_rsp_addr;

    logic               w_accept;
    logic               w_hit;

    assign w_accept = i_req_valid && (r_state == S_IDLE);
    // Invalid entries never match, whatever stale data they still hold.
    assign w_hit    = r_valid[r_idx] && (r_mem[r_idx] == r_key);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (i_req_op)
                        c_OP_NOP:   w_next = S_RESP;
                        c_OP_CLEAR: w_next = S_CLEAR;
                        default:    w_next = S_SCAN;
                    endcase
                end
            end
            S_SCAN: begin
                if (r_idx == c_LAST_IDX) begin
                    w_next = S_COMMIT;
                end
            end
            S_COMMIT: w_next = S_RESP;
            S_CLEAR:  w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, scan bookkeeping, table and response
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_valid       <= '0;
            r_count       <= '0;
            r_op          <= c_OP_NOP;
            r_key         <= '0;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_rsp_status  <= c_ST_OK;
            r_rsp_addr    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op          <= i_req_op;
                        r_key         <= i_req_key;
                        r_idx         <= '0;
                        r_match_found <= 1'b0;
                        r_match_idx   <= '0;
                        r_free_found  <= 1'b0;
                        r_free_idx    <= '0;
                        // NOP goes straight to RESP, so its result is set now.
                        if (i_req_op == c_OP_NOP) begin
                            r_rsp_status <= c_ST_OK;
                            r_rsp_addr   <= '0;
                        end
                    end
                end
                S_SCAN: begin
                    // Only the first hit / first hole is kept: lowest index wins.
                    if (w_hit && !r_match_found) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_idx;
                    end
                    if (!r_valid[r_idx] && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_idx;
                    end
                    r_idx <= r_idx + 1'b1;
                end
                S_COMMIT: begin
                    if (r_op == c_OP_INSERT) begin
                        if (r_match_found) begin
                            r_rsp_status <= c_ST_DUPLICATE;
                            r_rsp_addr   <= r_match_idx;
                        end else if (r_free_found) begin
                            r_mem[r_free_idx]   <= r_key;
                            r_valid[r_free_idx] <= 1'b1;
                            r_count             <= r_count + CW'(1);
                            r_rsp_status        <= c_ST_OK;
                            r_rsp_addr          <= r_free_idx;
                        end else begin
                            r_rsp_status <= c_ST_FULL;
                            r_rsp_addr   <= '0;
                        end
                    end else begin
                        // DELETE keeps the stored key; only the valid bit drops.
                        if (r_match_found) begin
                            r_valid[r_match_idx] <= 1'b0;
                            r_count              <= r_count - CW'(1);
                            r_rsp_status         <= c_ST_OK;
                            r_rsp_addr           <= r_match_idx;
                        end else begin
                            r_rsp_status <= c_ST_NOT_FOUND;
                            r_rsp_addr   <= '0;
                        end
                    end
                end
                S_CLEAR: begin
                    r_valid      <= '0;
                    r_count      <= '0;
                    r_rsp_status <= c_ST_OK;
                    r_rsp_addr   <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_req_ready   = (r_state == S_IDLE);
    assign o_rsp_valid   = (r_state == S_RESP);
    assign o_rsp_status  = r_rsp_status;
    assign o_rsp_addr    = r_rsp_addr;
    assign o_entry_valid = r_valid;
    assign o_entry_count = r_count;
    assign o_rd_data     = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: tb/tb_cam_update.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cam_update
//  Description : Self-checking bench for cam_update. A table-level model
//                (arrays of keys and valid flags plus a per-operation latency)
//                predicts every output each cycle; directed sequences pin the
//                model with hand-computed values, then random traffic runs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cam_update;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_key;
    logic             rsp_valid;
    logic [1:0]       rsp_status;
    logic [2:0]       rsp_addr;
    logic [DEPTH-1:0] entry_valid;
    logic [3:0]       entry_count;
    logic [2:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;

    always #5 clk = ~clk;

    cam_update #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_op      (req_op),
        .i_req_key     (req_key),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_status  (rsp_status),
        .o_rsp_addr    (rsp_addr),
        .o_entry_valid (entry_valid),
        .o_entry_count (entry_count),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: the table as arrays, a request as a countdown
    // ------------------------------------------------------------------
    logic             mv [DEPTH];
    logic [WIDTH-1:0] mk [DEPTH];
    bit               busy;
    int               rem;
    logic [1:0]       p_op;
    logic [WIDTH-1:0] p_key;
    bit               exp_rsp;
    logic [1:0]       exp_status;
    logic [2:0]       exp_addr;
    bit               cmp_on = 1'b0;

    function automatic int op_latency(logic [1:0] op);
        case (op)
            2'b00:   return 1;
            2'b11:   return 2;
            default: return 10;
        endcase
    endfunction

    function automatic logic [DEPTH-1:0] model_valid_vec();
        logic [DEPTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i] = mv[i];
        return v;
    endfunction

    function automatic void model_apply();
        int hit  = -1;
        int free = -1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (mv[i] && mk[i] == p_key) hit = i;
            if (!mv[i]) free = i;
        end
        exp_status = 2'b00;
        exp_addr   = 3'd0;
        case (p_op)
            2'b01: begin
                if (hit >= 0) begin
                    exp_status = 2'b01; exp_addr = 3'(hit);
                end else if (free >= 0) begin
                    mv[free] = 1'b1; mk[free] = p_key; exp_addr = 3'(free);
                end else begin
                    exp_status = 2'b10;
                end
            end
            2'b10: begin
                if (hit >= 0) begin
                    mv[hit] = 1'b0; exp_addr = 3'(hit);
                end else begin
                    exp_status = 2'b11;
                end
            end
            2'b11: for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
            default: ;
        endcase
        exp_rsp = 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mv[i] = 1'b0;
                mk[i] = '0;
            end
            busy = 1'b0; rem = 0; exp_rsp = 1'b0;
            exp_status = 2'b00; exp_addr = 3'd0;
        end else if (exp_rsp) begin
            exp_rsp = 1'b0;
            busy    = 1'b0;
        end else if (busy) begin
            rem--;
            if (rem == 0) model_apply();
        end else if (req_valid) begin
            busy  = 1'b1;
            p_op  = req_op;
            p_key = req_key;
            rem   = op_latency(req_op) - 1;
            if (rem == 0) model_apply();
        end
    end

    // One compare process: every output against the model, every cycle.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("req_ready",   32'(req_ready),   32'(!busy));
            chk("rsp_valid",   32'(rsp_valid),   32'(exp_rsp));
            chk("rsp_status",  32'(rsp_status),  32'(exp_status));
            chk("rsp_addr",    32'(rsp_addr),    32'(exp_addr));
            chk("entry_valid", 32'(entry_valid), 32'(model_valid_vec()));
            chk("entry_count", 32'(entry_count), 32'($countones(model_valid_vec())));
            chk("rd_data",     32'(rd_data),     32'(mk[rd_addr]));
        end
    end

    // ------------------------------------------------------------------
    // Directed request: wait for ready, issue, return latency and result.
    // While busy, req_valid is toggled with junk that must be ignored.
    // ------------------------------------------------------------------
    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] key,
                        output int lat, output logic [1:0] st, output logic [2:0] ad);
        int w = 0;
        while (!req_ready && w < 30) begin
            @(posedge clk); #2; w++;
        end
        req_valid = 1'b1; req_op = op; req_key = key;
        @(posedge clk); #2;
        lat = 0; st = 2'b00; ad = 3'd0;
        for (int n = 1; n <= 20; n++) begin
            if (rsp_valid) begin
                lat = n; st = rsp_status; ad = rsp_addr;
                break;
            end
            req_valid = 1'($urandom_range(0, 1));
            req_op    = 2'($urandom_range(0, 3));
            req_key   = 16'($urandom);
            @(posedge clk); #2;
        end
        req_valid = 1'b0;
    endtask

    int               lat;
    logic [1:0]       st;
    logic [2:0]       ad;
    int               seen;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_key = '0; rd_addr = 3'd0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cmp_on = 1'b1;

        // Reset state
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_count", 32'(entry_count), 32'd0);
        chk("rst_status", 32'(rsp_status), 32'd0);

        // First insert
        rd_addr = 3'd0;
        send(2'b01, 16'h00A5, lat, st, ad);
        chk("ins_lat", 32'(lat), 32'd10);
        chk("ins_status", 32'(st), 32'd0);
        chk("ins_addr", 32'(ad), 32'd0);
        chk("ins_valid", 32'(entry_valid), 32'h01);
        chk("ins_count", 32'(entry_count), 32'd1);
        chk("ins_rd", 32'(rd_data), 32'h00A5);

        // Duplicate
        send(2'b01, 16'h00A5, lat, st, ad);
        chk("dup_status", 32'(st), 32'd1);
        chk("dup_addr", 32'(ad), 32'd0);
        chk("dup_count", 32'(entry_count), 32'd1);

        // Fill to full, then overflow
        for (int i = 1; i < DEPTH; i++) begin
            send(2'b01, 16'h1000 + 16'(i), lat, st, ad);
            chk("fill_status", 32'(st), 32'd0);
            chk("fill_addr", 32'(ad), 32'(i));
        end
        send(2'b01, 16'h1234, lat, st, ad);
        chk("full_status", 32'(st), 32'd2);
        chk("full_addr", 32'(ad), 32'd0);
        chk("full_count", 32'(entry_count), 32'd8);

        // Delete index 3, reuse the hole
        send(2'b10, 16'h1003, lat, st, ad);
        chk("del_lat", 32'(lat), 32'd10);
        chk("del_status", 32'(st), 32'd0);
        chk("del_addr", 32'(ad), 32'd3);
        chk("del_valid", 32'(entry_valid), 32'hF7);
        rd_addr = 3'd3;
        send(2'b01, 16'hBEEF, lat, st, ad);
        chk("reins_status", 32'(st), 32'd0);
        chk("reins_addr", 32'(ad), 32'd3);
        chk("reins_valid", 32'(entry_valid), 32'hFF);
        chk("reins_rd", 32'(rd_data), 32'hBEEF);

        // Absent delete, clear, nop
        send(2'b10, 16'h7777, lat, st, ad);
        chk("nf_status", 32'(st), 32'd3);
        chk("nf_addr", 32'(ad), 32'd0);
        send(2'b11, 16'h0000, lat, st, ad);
        chk("clr_lat", 32'(lat), 32'd2);
        chk("clr_status", 32'(st), 32'd0);
        chk("clr_valid", 32'(entry_valid), 32'h00);
        chk("clr_count", 32'(entry_count), 32'd0);
        chk("clr_rd_kept", 32'(rd_data), 32'hBEEF);
        send(2'b00, 16'h0000, lat, st, ad);
        chk("nop_lat", 32'(lat), 32'd1);
        chk("nop_status", 32'(st), 32'd0);

        // Reset in the middle of a scan, with a stray request pulse
        send(2'b01, 16'h2222, lat, st, ad);
        chk("pre_rst_addr", 32'(ad), 32'd0);
        rd_addr = 3'd0;
        req_valid = 1'b1; req_op = 2'b01; req_key = 16'h5555;
        @(posedge clk); #2;
        req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #2; end
        req_valid = 1'b1; req_op = 2'b00;
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #2;
        end
        chk("mid_rst_no_rsp", 32'(seen), 32'd0);
        chk("mid_rst_valid", 32'(entry_valid), 32'h00);
        chk("mid_rst_count", 32'(entry_count), 32'd0);
        chk("mid_rst_rd", 32'(rd_data), 32'h0000);

        // Random traffic from a small key pool to provoke hits, duplicates and FULL
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = int'($urandom_range(0, 15));
            req_valid = ($urandom_range(0, 3) != 0);
            req_op    = (r < 7 || r == 15) ? 2'b01 : (r < 13) ? 2'b10 : (r == 13) ? 2'b00 : 2'b11;
            req_key   = 16'h0A00 + 16'($urandom_range(0, 9));
            rd_addr   = 3'($urandom_range(0, 7));
            rst_n     = ($urandom_range(0, 399) != 0);
            @(posedge clk); #2;
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #2; end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cam_update.md
CAM_UPDATE -- requirements
Module: cam_update

Interface
REQ-001 Parameter DEPTH, 8, number of CAM entries (entry index width 3).
REQ-002 Parameter WIDTH, 16, key width in bits.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_op  input  2  00 NOP, 01 INSERT, 10 DELETE, 11 CLEAR.
REQ-009 req_key  input  WIDTH  key to insert or delete.
REQ-010 rsp_valid  output  1  one-cycle response pulse.
REQ-011 rsp_status  output  2  00 OK, 01 DUPLICATE, 10 FULL, 11 NOT_FOUND.
REQ-012 rsp_addr  output  3  entry index affected or matched.
REQ-013 entry_valid  output  DEPTH  per-entry valid bits (lookup side qualifies matches with these).
REQ-014 entry_count  output  4  number of valid entries, 0..8.
REQ-015 rd_addr  input  3  lookup-side read index.
REQ-016 rd_data  output  WIDTH  stored key at rd_addr, combinational, returned regardless of valid.

Function
REQ-017 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; req_op and req_key are latched then.
REQ-018 req_ready SHALL be 1 only in IDLE; one request SHALL be outstanding at a time.
REQ-019 The FSM SHALL have states IDLE, SCAN, COMMIT, CLEAR, RESP.
REQ-020 Transitions: IDLE->SCAN on accepted INSERT/DELETE; IDLE->CLEAR on accepted CLEAR; IDLE->RESP on accepted NOP; SCAN->COMMIT after index 7; COMMIT->RESP; CLEAR->RESP; RESP->IDLE.
REQ-021 SCAN SHALL examine one entry per cycle, index 0 through 7, 8 cycles total.
REQ-022 SCAN SHALL record the lowest matching index among valid entries and the lowest invalid index.
REQ-023 Invalid entries SHALL never match, whatever data they hold.
REQ-024 INSERT at COMMIT: on match, no write, DUPLICATE, addr = match index.
REQ-025 INSERT at COMMIT: otherwise, if a free slot exists, write the key and set its valid bit; OK, addr = that slot.
REQ-026 INSERT at COMMIT: otherwise FULL, addr = 0, table unchanged.
REQ-027 DELETE at COMMIT: on match, clear that valid bit and retain the data; OK, addr = match index.
REQ-028 DELETE at COMMIT: otherwise NOT_FOUND, addr = 0.
REQ-029 CLEAR SHALL clear all valid bits in one cycle, data retained; OK, addr = 0.
REQ-030 NOP SHALL leave the table unchanged; OK, addr = 0.
REQ-031 rsp_valid SHALL be 1 for exactly the RESP cycle; rsp_status and rsp_addr hold their values until the next response.
REQ-032 Latency, counted in cycles after the accepting edge:
- INSERT/DELETE: rsp_valid high in cycle 10.
- CLEAR: rsp_valid high in cycle 2.
- NOP: rsp_valid high in cycle 1.
REQ-033 entry_valid and entry_count SHALL be registered, changing on the COMMIT or CLEAR edge; entry_count SHALL always equal popcount(entry_valid).
REQ-034 The key width and the 4-bit count SHALL not wrap: count never exceeds 8, and INSERT when full yields FULL.
REQ-035 req_valid asserted outside IDLE SHALL be ignored, with no latching and no side effects.
REQ-036 rd_data SHALL reflect a COMMIT write from the cycle after the write edge.

Reset
REQ-037 When rst_n=0 at a rising edge:
- state = IDLE, req_ready = 1, rsp_valid = 0, rsp_status = 00, rsp_addr = 0;
- entry_valid = 0, entry_count = 0, all stored keys = 0.
REQ-038 Reset mid-operation SHALL abort the request: no response, no partial write, and the table is cleared.

Verification
REQ-039 Reset, then INSERT 0x00A5 -> rsp_valid in cycle 10, OK, addr 0, entry_valid=0x01, count 1, rd_data[0]=0x00A5.
REQ-040 INSERT 0x00A5 again -> DUPLICATE, addr 0, count stays 1.
REQ-041 INSERT 8 distinct keys, then 0x1234 -> responses addr 0..7 OK, then FULL addr 0, count 8.
REQ-042 From full, DELETE key at index 3, then INSERT 0xBEEF -> OK addr 3 twice, entry_valid=0xFF, rd_data[3]=0xBEEF.
REQ-043 DELETE absent key 0x7777 -> NOT_FOUND addr 0; CLEAR -> OK in cycle 2, entry_valid=0, count 0.
REQ-044 rst_n low during SCAN of an INSERT, then req_valid pulsed mid-SCAN -> no rsp_valid, table empty, ready=1 after reset, and the mid-SCAN pulse ignored.
